// File: rtl/adc_scan_capture.sv
// ADC scan sequencer: issues conversion requests over a channel mask and buffers
// {channel, sample} results in a show-ahead FIFO with sticky overflow/timeout flags.
module adc_scan_capture #(
  parameter int NB_CHANNEL  = 4,
  parameter int DATA_WIDTH  = 12,
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 1024,
  localparam int CH_W  = $clog2(NB_CHANNEL),
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic                       i_cmd_start,
  input  logic                       i_cmd_stop,
  input  logic [1:0]                 i_cmd_mode,
  input  logic [CH_W-1:0]            i_cmd_chan,
  input  logic [NB_CHANNEL-1:0]      i_chan_mask,
  output logic                       o_adc_req,
  output logic [CH_W-1:0]            o_adc_chan,
  input  logic                       i_adc_ack,
  input  logic [DATA_WIDTH-1:0]      i_adc_data,
  output logic [CH_W+DATA_WIDTH-1:0] o_fifo_data,
  input  logic                       i_fifo_rd,
  output logic                       o_fifo_empty,
  output logic                       o_fifo_full,
  output logic [CNT_W-1:0]           o_fifo_count,
  output logic                       o_busy,
  output logic                       o_overflow,
  output logic                       o_timeout,
  input  logic                       i_clr_status
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int E_W   = CH_W + DATA_WIDTH;
  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_ONCE   = 2'b01;
  localparam logic [1:0] MODE_CONT   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_ACK, S_NEXT} state_t;

  // {found, index} of the lowest set bit of m at position start or above
  function automatic logic [CH_W:0] find_from(input logic [NB_CHANNEL-1:0] m, input int start);
    logic [CH_W:0] res;
    res = '0;
    for (int i = NB_CHANNEL - 1; i >= 0; i--) begin
      if (m[i] && i >= start) res = {1'b1, CH_W'(i)};
    end
    return res;
  endfunction

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [NB_CHANNEL-1:0] r_mask;
  logic                  r_stop_pend;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_adc_req;
  logic [CH_W-1:0]       r_adc_chan;
  logic                  r_overflow;
  logic                  r_timeout;

  logic [E_W-1:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [CH_W:0] w_first;
  logic [CH_W:0] w_next;
  logic [CH_W:0] w_wrap;
  logic          w_start_ok;
  logic          w_push;
  logic          w_to_evt;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;

  assign w_first    = find_from(i_chan_mask, 0);
  assign w_next     = find_from(r_mask, int'(r_adc_chan) + 1);
  assign w_wrap     = find_from(r_mask, 0);
  assign w_start_ok = (i_cmd_mode == MODE_SINGLE) ||
                      ((i_cmd_mode == MODE_ONCE || i_cmd_mode == MODE_CONT) && w_first[CH_W]);
  assign w_push     = (r_state == S_WAIT_ACK) && i_adc_ack;
  assign w_to_evt   = (r_state == S_WAIT_ACK) && !i_adc_ack &&
                      (r_to_cnt == TO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state     <= S_IDLE;
      r_mode      <= MODE_SINGLE;
      r_mask      <= '0;
      r_stop_pend <= 1'b0;
      r_to_cnt    <= '0;
      r_adc_req   <= 1'b0;
      r_adc_chan  <= '0;
    end else begin
      r_adc_req <= 1'b0;
      if (i_cmd_stop && r_state != S_IDLE) r_stop_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          // a stop in the same cycle as start cancels the start
          if (i_cmd_start && !i_cmd_stop && w_start_ok) begin
            r_mode     <= i_cmd_mode;
            r_mask     <= i_chan_mask;
            r_adc_chan <= (i_cmd_mode == MODE_SINGLE) ? i_cmd_chan : w_first[CH_W-1:0];
            r_adc_req  <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (i_adc_ack || w_to_evt) r_state <= S_NEXT;
          else                       r_to_cnt <= r_to_cnt + TO_W'(1);
        end
        S_NEXT: begin
          if (r_stop_pend || i_cmd_stop || r_mode == MODE_SINGLE) begin
            r_stop_pend <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_next[CH_W]) begin
            r_adc_chan <= w_next[CH_W-1:0];
            r_adc_req  <= 1'b1;
            r_state    <= S_REQ;
          end else if (r_mode == MODE_CONT && w_wrap[CH_W]) begin
            r_adc_chan <= w_wrap[CH_W-1:0];
            r_adc_req  <= 1'b1;
            r_state    <= S_REQ;
          end else begin
            r_stop_pend <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a push when a pop frees the head in the same cycle
  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop  = i_fifo_rd && (r_count != '0);
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_adc_chan, i_adc_data};
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset || i_clr_status) begin
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_push && !w_wr) r_overflow <= 1'b1;
      if (w_to_evt)        r_timeout  <= 1'b1;
    end
  end

  assign o_adc_req    = r_adc_req;
  assign o_adc_chan   = r_adc_chan;
  assign o_busy       = (r_state != S_IDLE);
  assign o_fifo_data  = r_mem[r_rd_ptr];
  assign o_fifo_empty = (r_count == '0);
  assign o_fifo_full  = w_full;
  assign o_fifo_count = r_count;
  assign o_overflow   = r_overflow;
  assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_adc_scan_capture.sv
// Randomized bench for adc_scan_capture: the bench plays the ADC and predicts
// the channel sequence, FIFO contents and status flags from a queue-based model.
module tb_adc_scan_capture;
  localparam int NB    = 4;
  localparam int DW    = 12;
  localparam int DEPTH = 16;
  localparam int T     = 8;
  localparam int CW    = 2;
  localparam int EW    = CW + DW;

  logic          clk_clk = 1'b0;
  logic          reset_reset;
  logic          i_cmd_start, i_cmd_stop;
  logic [1:0]    i_cmd_mode;
  logic [CW-1:0] i_cmd_chan;
  logic [NB-1:0] i_chan_mask;
  logic          o_adc_req;
  logic [CW-1:0] o_adc_chan;
  logic          i_adc_ack;
  logic [DW-1:0] i_adc_data;
  logic [EW-1:0] o_fifo_data;
  logic          i_fifo_rd;
  logic          o_fifo_empty, o_fifo_full;
  logic [4:0]    o_fifo_count;
  logic          o_busy, o_overflow, o_timeout;
  logic          i_clr_status;

  adc_scan_capture #(
    .NB_CHANNEL(NB), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(T)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .i_cmd_start(i_cmd_start), .i_cmd_stop(i_cmd_stop), .i_cmd_mode(i_cmd_mode),
    .i_cmd_chan(i_cmd_chan), .i_chan_mask(i_chan_mask),
    .o_adc_req(o_adc_req), .o_adc_chan(o_adc_chan),
    .i_adc_ack(i_adc_ack), .i_adc_data(i_adc_data),
    .o_fifo_data(o_fifo_data), .i_fifo_rd(i_fifo_rd),
    .o_fifo_empty(o_fifo_empty), .o_fifo_full(o_fifo_full), .o_fifo_count(o_fifo_count),
    .o_busy(o_busy), .o_overflow(o_overflow), .o_timeout(o_timeout),
    .i_clr_status(i_clr_status)
  );

  always #5 clk_clk = ~clk_clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [EW-1:0] m_q[$];
  bit            m_ovf = 0;
  bit            m_to  = 0;
  bit            ev_push = 0;
  bit            ev_to   = 0;
  logic [EW-1:0] ev_entry;
  int            rd_pct  = 0;
  int            clr_pct = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_set(input logic [NB-1:0] m, input int s);
    for (int i = s; i < NB; i++) if (m[i]) return i;
    return -1;
  endfunction

  // one clock: update the model with the inputs seen at the edge, then compare
  task automatic tick();
    bit pop_ok, push_ok;
    @(posedge clk_clk);
    if (reset_reset) begin
      m_q.delete();
      m_ovf = 0;
      m_to  = 0;
    end else begin
      pop_ok  = i_fifo_rd && (m_q.size() > 0);
      push_ok = ev_push && ((m_q.size() < DEPTH) || pop_ok);
      if (pop_ok)  void'(m_q.pop_front());
      if (push_ok) m_q.push_back(ev_entry);
      if (i_clr_status) begin
        m_ovf = 0;
        m_to  = 0;
      end else begin
        if (ev_push && !push_ok) m_ovf = 1;
        if (ev_to) m_to = 1;
      end
    end
    ev_push = 0;
    ev_to   = 0;
    #1;
    check_val("count", 32'(o_fifo_count), m_q.size());
    check_val("empty", 32'(o_fifo_empty), 32'(m_q.size() == 0));
    check_val("full", 32'(o_fifo_full), 32'(m_q.size() == DEPTH));
    check_val("overflow", 32'(o_overflow), 32'(m_ovf));
    check_val("timeout", 32'(o_timeout), 32'(m_to));
    if (m_q.size() > 0) check_val("head", 32'(o_fifo_data), 32'(m_q[0]));
    i_fifo_rd    = ($urandom_range(0, 99) < rd_pct);
    i_clr_status = ($urandom_range(0, 99) < clr_pct);
  endtask

  task automatic drain();
    rd_pct    = 100;
    i_fifo_rd = 1'b1;
    repeat (DEPTH + 2) tick();
    rd_pct    = 0;
    i_fifo_rd = 1'b0;
    check_val("drain_empty", 32'(o_fifo_empty), 1);
  endtask

  // Issue one start command and act as the converter until the block returns idle.
  // stop_at: conversion number during which stop is pulsed (0 = never).
  // force_d: ack delay in WAIT cycles (0 = random, >T = no ack); force_data < 0 = random.
  task automatic do_cmd(input logic [1:0] mode, input int chan, input logic [NB-1:0] mask,
                        input int stop_at, input bit stop_with_start,
                        input int force_d, input int force_data);
    bit            accepted, done, timed_out;
    int            exp_ch, conv, d, d_eff, stop_k, nxt;
    logic [DW-1:0] data;
    accepted = !stop_with_start &&
               (mode == 2'b00 || ((mode == 2'b01 || mode == 2'b10) && mask != '0));
    i_cmd_start = 1'b1;
    i_cmd_stop  = stop_with_start;
    i_cmd_mode  = mode;
    i_cmd_chan  = CW'(chan);
    i_chan_mask = mask;
    tick();
    i_cmd_start = 1'b0;
    i_cmd_stop  = 1'b0;
    i_cmd_mode  = 2'($urandom);
    i_cmd_chan  = CW'($urandom);
    i_chan_mask = NB'($urandom);
    conv = 0;
    if (!accepted) begin
      check_val("ignored_busy", 32'(o_busy), 0);
      check_val("ignored_req", 32'(o_adc_req), 0);
      $display("cmd mode=%0d chan=%0d mask=%b stop=%0d ignored", mode, chan, mask, stop_with_start);
      return;
    end
    exp_ch = (mode == 2'b00) ? chan : first_set(mask, 0);
    done = 0;
    while (!done) begin
      check_val("req", 32'(o_adc_req), 1);
      check_val("req_chan", 32'(o_adc_chan), exp_ch);
      check_val("busy", 32'(o_busy), 1);
      if (o_adc_req !== 1'b1) return;
      conv++;
      if (conv > 64) begin
        check_val("conv_limit", conv, 64);
        return;
      end
      d      = (force_d > 0) ? force_d : $urandom_range(1, T + 1);
      d_eff  = (d < T) ? d : T;
      stop_k = (conv == stop_at) ? $urandom_range(0, d_eff) : -1;
      // REQ cycle: ack and start here must both be ignored
      i_adc_ack   = 1'($urandom_range(0, 1));
      i_adc_data  = DW'($urandom);
      i_cmd_stop  = (stop_k == 0);
      i_cmd_start = 1'($urandom_range(0, 1));
      tick();
      i_cmd_stop  = 1'b0;
      i_cmd_start = 1'b0;
      timed_out = 1;
      for (int k = 1; k <= T; k++) begin
        check_val("req_low", 32'(o_adc_req), 0);
        check_val("chan_hold", 32'(o_adc_chan), exp_ch);
        data = (force_d > 0 && force_data >= 0) ? DW'(force_data) : DW'($urandom);
        i_adc_ack   = (k == d);
        i_adc_data  = data;
        i_cmd_stop  = (k == stop_k);
        i_cmd_start = ($urandom_range(0, 3) == 0);
        if (k == d) begin
          ev_push  = 1;
          ev_entry = {CW'(exp_ch), data};
        end
        if (k == T && k != d) ev_to = 1;
        tick();
        i_cmd_stop  = 1'b0;
        i_cmd_start = 1'b0;
        if (k == d) begin
          timed_out = 0;
          break;
        end
      end
      // NEXT cycle: a late ack here is ignored
      i_adc_ack = 1'($urandom_range(0, 1));
      tick();
      i_adc_ack = 1'b0;
      nxt = first_set(mask, exp_ch + 1);
      if (conv >= stop_at && stop_at > 0) done = 1;
      else if (mode == 2'b00) done = 1;
      else if (nxt >= 0) exp_ch = nxt;
      else if (mode == 2'b10) exp_ch = first_set(mask, 0);
      else done = 1;
      if (timed_out) $display("  chan %0d timed out", exp_ch);
    end
    check_val("idle_busy", 32'(o_busy), 0);
    check_val("idle_req", 32'(o_adc_req), 0);
    $display("cmd mode=%0d chan=%0d mask=%b stop_at=%0d conversions=%0d fifo=%0d",
             mode, chan, mask, stop_at, conv, m_q.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_reset  = 1'b1;
    i_cmd_start  = 1'b0;
    i_cmd_stop   = 1'b0;
    i_cmd_mode   = 2'b00;
    i_cmd_chan   = '0;
    i_chan_mask  = '0;
    i_adc_ack    = 1'b0;
    i_adc_data   = '0;
    i_fifo_rd    = 1'b0;
    i_clr_status = 1'b0;
    tick();
    tick();
    reset_reset = 1'b0;
    check_val("rst_busy", 32'(o_busy), 0);
    check_val("rst_req", 32'(o_adc_req), 0);
    check_val("rst_chan", 32'(o_adc_chan), 0);
    check_val("rst_empty", 32'(o_fifo_empty), 1);
    tick();

    // single conversion, channel 2, data 0xABC after 5 wait cycles
    do_cmd(2'b00, 2, 4'b0000, 0, 0, 5, 12'hABC);
    check_val("single_head", 32'(o_fifo_data), 32'h2ABC);
    check_val("single_count", 32'(o_fifo_count), 1);
    drain();

    // scan-once over mask 1010
    do_cmd(2'b01, 0, 4'b1010, 0, 0, 0, -1);
    check_val("once_head_chan", 32'(o_fifo_data[EW-1:DW]), 1);
    drain();

    // continuous over 0101 stopped during the 3rd conversion
    do_cmd(2'b10, 0, 4'b0101, 3, 0, 2, -1);
    check_val("cont_count", 32'(o_fifo_count), 3);
    drain();

    // ignored starts: reserved mode, empty scan mask, start with stop
    do_cmd(2'b11, 1, 4'b1111, 0, 0, 0, -1);
    do_cmd(2'b01, 0, 4'b0000, 0, 0, 0, -1);
    do_cmd(2'b00, 1, 4'b0000, 0, 1, 0, -1);

    // stop while idle must not leave a pending stop behind
    i_cmd_stop = 1'b1;
    tick();
    i_cmd_stop = 1'b0;
    do_cmd(2'b01, 0, 4'b1111, 0, 0, 1, -1);
    check_val("idle_stop_count", 32'(o_fifo_count), 4);
    drain();

    // overflow: 17 samples with no pops
    do_cmd(2'b10, 0, 4'b1111, 17, 0, 2, -1);
    check_val("ovf_full", 32'(o_fifo_full), 1);
    check_val("ovf_flag", 32'(o_overflow), 1);
    check_val("ovf_head_chan", 32'(o_fifo_data[EW-1:DW]), 0);
    i_clr_status = 1'b1;
    tick();
    check_val("ovf_cleared", 32'(o_overflow), 0);
    drain();

    // timeout: single conversion with no ack
    do_cmd(2'b00, 1, 4'b0000, 0, 0, T + 1, -1);
    check_val("to_flag", 32'(o_timeout), 1);
    check_val("to_empty", 32'(o_fifo_empty), 1);
    i_clr_status = 1'b1;
    tick();
    check_val("to_cleared", 32'(o_timeout), 0);

    // reset while waiting for ack discards FIFO contents and ignores the late ack
    do_cmd(2'b01, 0, 4'b0011, 0, 0, 1, -1);
    i_cmd_start = 1'b1;
    i_cmd_mode  = 2'b00;
    i_cmd_chan  = 2'd3;
    tick();
    i_cmd_start = 1'b0;
    tick();
    tick();
    check_val("pre_rst_busy", 32'(o_busy), 1);
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
    i_adc_ack   = 1'b1;
    i_adc_data  = DW'($urandom);
    tick();
    i_adc_ack = 1'b0;
    tick();
    check_val("rst_mid_busy", 32'(o_busy), 0);
    check_val("rst_mid_empty", 32'(o_fifo_empty), 1);
    check_val("rst_mid_req", 32'(o_adc_req), 0);
    $display("reset during wait: fifo=%0d busy=%0d", o_fifo_count, o_busy);

    // randomized commands with random pops and status clears
    rd_pct  = 40;
    clr_pct = 5;
    for (int n = 0; n < 40; n++) begin
      logic [1:0]    mode;
      logic [NB-1:0] mask;
      int            stop_at;
      mode    = 2'($urandom_range(0, 3));
      mask    = NB'($urandom);
      stop_at = (mode == 2'b10) ? $urandom_range(1, 6) : $urandom_range(0, 3);
      do_cmd(mode, $urandom_range(0, NB - 1), mask, stop_at,
             ($urandom_range(0, 9) == 0), 0, -1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
